// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports and the shared data-memory bus.
// The arbiter takes the slave view; requesters and memory take the master view.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter for the single-port data memory, with
// registered one-cycle read responses per port.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    logic last;
    logic win0;
    logic win1;
    logic rd0;
    logic rd1;

    // The port that did not win last time takes priority on contention.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (!reset) begin
            win0 = bus.req0_valid & (~bus.req1_valid | last);
            win1 = bus.req1_valid & (~bus.req0_valid | ~last);
        end
    end

    assign rd0 = win0 & ~bus.req0_we;
    assign rd1 = win1 & ~bus.req1_we;

    assign bus.req0_ready = win0;
    assign bus.req1_ready = win1;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        unique case (1'b1)
            win0: begin
                bus.mem_addr  = bus.req0_addr;
                bus.mem_wdata = bus.req0_wdata;
                bus.mem_write = bus.req0_we;
                bus.mem_read  = ~bus.req0_we;
            end
            win1: begin
                bus.mem_addr  = bus.req1_addr;
                bus.mem_wdata = bus.req1_wdata;
                bus.mem_write = bus.req1_we;
                bus.mem_read  = ~bus.req1_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last           <= 1'b1;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp0_rdata <= '0;
            bus.rsp1_rdata <= '0;
        end else begin
            bus.rsp0_valid <= rd0;
            bus.rsp1_valid <= rd1;
            if (rd0) bus.rsp0_rdata <= bus.mem_rdata;
            if (rd1) bus.rsp1_rdata <= bus.mem_rdata;
            if (win0)      last <= 1'b0;
            else if (win1) last <= 1'b1;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: reference arbiter and shadow
// memory predict grants, bus drive and read responses each cycle.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic reset;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] sh  [256];

    // Poison value when not reading exposes any stray sampling.
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 8'hEE;

    always @(posedge clk)
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    logic       mlast;
    logic [7:0] held0, held1;
    logic       g0, g1;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic v0, input logic we0,
                        input logic [7:0] a0, input logic [7:0] d0,
                        input logic v1, input logic we1,
                        input logic [7:0] a1, input logic [7:0] d1,
                        input logic rst);
        logic p0, p1;
        logic [7:0] ea, ed;
        reset          = rst;
        bus.req0_valid = v0;
        bus.req0_we    = we0;
        bus.req0_addr  = a0;
        bus.req0_wdata = d0;
        bus.req1_valid = v1;
        bus.req1_we    = we1;
        bus.req1_addr  = a1;
        bus.req1_wdata = d1;
        @(negedge clk);
        g0 = !rst && v0 && (!v1 || mlast);
        g1 = !rst && v1 && (!v0 || !mlast);
        ea = g0 ? a0 : g1 ? a1 : 8'h00;
        ed = g0 ? d0 : g1 ? d1 : 8'h00;
        chk("req0_ready", bus.req0_ready, g0);
        chk("req1_ready", bus.req1_ready, g1);
        chk("mem_write", bus.mem_write, (g0 && we0) || (g1 && we1));
        chk("mem_read", bus.mem_read, (g0 && !we0) || (g1 && !we1));
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_wdata, ed);
        p0 = g0 && !we0;
        p1 = g1 && !we1;
        if (p0) q0.push_back(sh[a0]);
        if (p1) q1.push_back(sh[a1]);
        @(posedge clk);
        #1;
        if (rst) begin
            mlast = 1'b1;
            held0 = 8'h00;
            held1 = 8'h00;
            q0.delete();
            q1.delete();
            p0 = 1'b0;
            p1 = 1'b0;
        end else begin
            if (g0) mlast = 1'b0;
            else if (g1) mlast = 1'b1;
            if (g0 && we0) sh[a0] = d0;
            if (g1 && we1) sh[a1] = d1;
        end
        if (p0 && q0.size() > 0) held0 = q0.pop_front();
        if (p1 && q1.size() > 0) held1 = q1.pop_front();
        chk("rsp0_valid", bus.rsp0_valid, p0);
        chk("rsp1_valid", bus.rsp1_valid, p1);
        chk("rsp0_rdata", bus.rsp0_rdata, held0);
        chk("rsp1_rdata", bus.rsp1_rdata, held1);
    endtask

    task automatic idle(input logic rst);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, rst);
    endtask

    initial begin
        logic       pv0, pw0, pv1, pw1;
        logic [7:0] pa0, pd0, pa1, pd1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 7 + 3);
            sh[i]  = 8'(i * 7 + 3);
        end
        mlast = 1'b1;
        held0 = 8'h00;
        held1 = 8'h00;
        idle(1);
        idle(1);

        // Write then read back on port 0
        step(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 0);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        chk("raw_5a", bus.rsp0_rdata, 8'h5A);
        idle(0);

        // Continuous contention: strict alternation
        step(1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0);
            chk("alt_grant", {bus.rsp1_valid, bus.rsp0_valid},
                (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Port 1 write, port 0 read-after-write
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hFF, 0);
        step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        chk("raw_ff", bus.rsp0_rdata, 8'hFF);

        // Reset blocks a pending write; port 0 wins first contention after
        step(1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h33, 1);
        step(1, 0, 8'h40, 8'h00, 1, 0, 8'h10, 8'h00, 0);
        chk("rst_keep40", bus.rsp0_rdata, 8'h77);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0);

        // Reset right after a read transfer kills later response state
        step(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        idle(1);

        // Read, then idle with held data
        step(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 3; i++) idle(0);

        // Random traffic obeying the hold-until-ready rule
        pv0 = 0; pv1 = 0;
        pw0 = 0; pw1 = 0;
        pa0 = 0; pa1 = 0;
        pd0 = 0; pd1 = 0;
        for (int i = 0; i < 60; i++) begin
            if (!pv0) begin
                pv0 = 1'($urandom_range(0, 1));
                pw0 = 1'($urandom_range(0, 1));
                pa0 = 8'($urandom_range(0, 7));
                pd0 = 8'($urandom);
            end
            if (!pv1) begin
                pv1 = 1'($urandom_range(0, 1));
                pw1 = 1'($urandom_range(0, 1));
                pa1 = 8'($urandom_range(0, 7));
                pd1 = 8'($urandom);
            end
            step(pv0, pw0, pa0, pd0, pv1, pw1, pa1, pd1, 0);
            if (g0) pv0 = 0;
            if (g1) pv1 = 0;
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
